// File: rtl/timer_irq_source_if.sv
// Peripheral bus bundle for timer_irq_source: word select, write strobe, write/read data.
// Latency: rdata is combinational on addr; writes are sampled at the clock edge.
// Backpressure: none, every access completes in the cycle it is presented.
//
// Ports (signals):
//   addr  [1:0]      word select (bus address[3:2])
//   we               write strobe
//   wdata [WIDTH-1:0] write data
//   rdata [WIDTH-1:0] read data for addr
interface timer_irq_source_if #(
  parameter int WIDTH = 32
) ();
  logic [1:0]       addr;
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_irq_source.sv
// Down-counting timer peripheral raising one CP0 interrupt line (one-shot level / auto-reload pulse).
// Latency: irq rises PRESET+3 edges after the edge that writes EN=1; reads are combinational.
// Backpressure: none, register accesses are accepted every cycle.
//
// Ports:
//   clk    system clock, all state changes on posedge
//   reset  asynchronous active-low reset
//   bus    slave side of the register bus (addr/we/wdata in, rdata out)
//   irq    interrupt request, decoded from registered state only
module timer_irq_source #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  timer_irq_source_if.slave bus,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic ctrl_wr;
  logic preset_wr;
  logic auto_reload;

  assign ctrl_wr     = bus.we && (bus.addr == 2'd0);
  assign preset_wr   = bus.we && (bus.addr == 2'd1);
  // Only MODE==1 reloads; the two unused encodings fall back to one-shot.
  assign auto_reload = (mode_q == 2'd1);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          state_d = ST_INT;
          // One-shot disarms itself so software must re-enable explicitly.
          if (!auto_reload) en_d = 1'b0;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          state_d = en_q ? ST_LOAD : ST_IDLE;
        end else if (ctrl_wr) begin
          // Any CTRL write acknowledges a one-shot interrupt.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus writes are applied last so they override the EN auto-clear on the same edge.
    if (ctrl_wr) begin
      en_d   = bus.wdata[0];
      mode_d = bus.wdata[2:1];
      im_d   = bus.wdata[3];
    end
    if (preset_wr) preset_d = bus.wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      2'd0:    bus.rdata = {{(WIDTH-4){1'b0}}, im_q, mode_q, en_q};
      2'd1:    bus.rdata = preset_q;
      2'd2:    bus.rdata = count_q;
      default: bus.rdata = '0;
    endcase
  end

  assign irq = (state_q == ST_INT) && im_q;

endmodule

// File: tb/tb_timer_irq_source.sv
module tb_timer_irq_source;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;

  timer_irq_source_if #(.WIDTH(32)) bus ();

  timer_irq_source #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: register file plus a phase number taken straight from the behaviour rules.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;
  bit        m_en, m_im;
  bit [1:0]  m_mode;
  bit [31:0] m_preset, m_count;
  int        m_ph;

  function automatic void m_reset();
    m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0; m_ph = PH_IDLE;
  endfunction

  function automatic void m_step(input bit w, input bit [1:0] a, input bit [31:0] d);
    bit ctrl_wr;
    ctrl_wr = w && (a == 2'd0);
    if (m_ph == PH_IDLE) begin
      if (m_en) m_ph = PH_LOAD;
    end else if (m_ph == PH_LOAD) begin
      m_count = m_preset;
      m_ph = PH_CNT;
    end else if (m_ph == PH_CNT) begin
      if (!m_en) m_ph = PH_IDLE;
      else if (m_count == 0) begin
        m_ph = PH_INT;
        if (m_mode != 2'd1) m_en = 0;
      end else m_count = m_count - 1;
    end else begin
      if (m_mode == 2'd1) m_ph = m_en ? PH_LOAD : PH_IDLE;
      else if (ctrl_wr) m_ph = PH_IDLE;
    end
    if (ctrl_wr) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
    end
    if (w && a == 2'd1) m_preset = d;
  endfunction

  function automatic bit [31:0] m_rd(input bit [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle, let the edge happen, advance the model, settle past the edge.
  task automatic tick(input bit w, input bit [1:0] a, input bit [31:0] d);
    bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    m_step(w, a, d);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input bit [1:0] a, output logic [31:0] v);
    bus.we = 1'b0; bus.addr = a;
    #1;
    v = bus.rdata;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    chk({tag, "_irq"}, {31'd0, irq}, {31'd0, (m_ph == PH_INT) && m_im});
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk($sformatf("%s_rd%0d", tag, a), v, m_rd(2'(a)));
    end
  endtask

  initial begin
    logic [31:0] v;
    bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
    m_reset();

    // Power-on reset
    @(posedge clk); @(posedge clk); #1;
    check_all("por");
    reset = 1'b1;

    // 1: reset mid-count with COUNT=7
    tick(1, 2'd1, 32'd7);
    tick(1, 2'd0, 32'd1);
    idle(); idle();
    rd(2'd2, v); chk("t1_count7", v, 32'd7);
    reset = 1'b0;
    m_reset();
    #1;
    chk("t1_irq_rst", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v); chk($sformatf("t1_rst_rd%0d", a), v, 32'd0);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(); check_all("t1_post");
    end

    // 2: one-shot, PRESET=5, IM set
    tick(1, 2'd1, 32'd5);
    tick(1, 2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      idle();
      chk($sformatf("t2_irq_e%0d", k), {31'd0, irq}, {31'd0, k == 8});
    end
    rd(2'd0, v); chk("t2_ctrl", v, 32'h8);
    rd(2'd2, v); chk("t2_count", v, 32'd0);
    idle();
    chk("t2_irq_held", {31'd0, irq}, 32'd1);
    tick(1, 2'd0, 32'd0);
    chk("t2_irq_ack", {31'd0, irq}, 32'd0);
    check_all("t2_end");

    // 3: auto-reload, PRESET=3 -> pulse every 6 cycles
    tick(1, 2'd1, 32'd3);
    tick(1, 2'd0, 32'hB);
    for (int k = 1; k <= 19; k++) begin
      idle();
      chk($sformatf("t3_irq_e%0d", k), {31'd0, irq}, {31'd0, (k == 6) || (k == 12) || (k == 18)});
      if (k >= 2 && k <= 5) begin
        rd(2'd2, v); chk($sformatf("t3_count_e%0d", k), v, 32'(5 - k));
      end
      check_all("t3");
    end
    tick(1, 2'd0, 32'd0);
    idle(); idle();
    check_all("t3_stop");

    // 4: clear EN with COUNT landing on 4
    tick(1, 2'd1, 32'd8);
    tick(1, 2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) idle();
    tick(1, 2'd0, 32'd0);
    rd(2'd2, v); chk("t4_count_clr", v, 32'd4);
    for (int k = 0; k < 5; k++) begin
      idle();
      chk("t4_irq", {31'd0, irq}, 32'd0);
      rd(2'd2, v); chk("t4_count_hold", v, 32'd4);
    end

    // 5: CTRL write racing the EN auto-clear, then PRESET=0
    tick(1, 2'd1, 32'd2);
    tick(1, 2'd0, 32'h1);
    for (int k = 1; k <= 4; k++) idle();
    tick(1, 2'd0, 32'h9);
    rd(2'd0, v); chk("t5_ctrl_race", v, 32'h9);
    chk("t5_irq_race", {31'd0, irq}, 32'd1);
    tick(1, 2'd0, 32'd0);
    chk("t5_irq_ack", {31'd0, irq}, 32'd0);
    tick(1, 2'd1, 32'd0);
    tick(1, 2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      idle();
      chk($sformatf("t5_p0_e%0d", k), {31'd0, irq}, {31'd0, k == 3});
    end
    tick(1, 2'd0, 32'd0);
    check_all("t5_end");

    // 6: ignored writes, PRESET change mid-count
    tick(1, 2'd2, 32'h55);
    tick(1, 2'd3, 32'hAA);
    rd(2'd2, v); chk("t6_count_ro", v, 32'd0);
    rd(2'd3, v); chk("t6_rsvd", v, 32'd0);
    tick(1, 2'd1, 32'd2);
    tick(1, 2'd0, 32'hB);
    for (int k = 1; k <= 17; k++) begin
      if (k == 3) tick(1, 2'd1, 32'd9);
      else idle();
      chk($sformatf("t6_irq_e%0d", k), {31'd0, irq}, {31'd0, (k == 5) || (k == 17)});
      if (k == 7) begin
        rd(2'd2, v); chk("t6_reload9", v, 32'd9);
      end
    end
    tick(1, 2'd0, 32'd0);
    idle(); idle();

    // All-ones PRESET only decrements
    tick(1, 2'd1, 32'hFFFF_FFFF);
    tick(1, 2'd0, 32'h1);
    idle(); idle();
    rd(2'd2, v); chk("max_load", v, 32'hFFFF_FFFF);
    idle();
    rd(2'd2, v); chk("max_dec", v, 32'hFFFF_FFFE);
    tick(1, 2'd0, 32'd0);
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit        w;
      bit [1:0]  a;
      bit [31:0] d;
      w = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 6);
      if (a == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      tick(w, a, d);
      check_all("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
